// File: rtl/slc3_memory.sv
// Purpose: SLC-3 memory responder: word RAM, switch/hex I/O word at 0xFFFF, optional boot-clear.
// Latency: reads 1 cycle (mem_rdata registered and held); writes take effect on the sampling edge.
// Backpressure: none; one request per cycle is accepted, except while boot-clear runs (requests dropped).
//
// Ports: clk, reset (sync, active-high); mem_addr/mem_wdata/mem_mem_ena/mem_wr_ena request bus;
//        mem_rdata read data; sw_i async switches; hex_o display register; init_busy_o clear busy.
// Option: define SLC3_MEM_CLEAR_EN to compile in the boot-clear FSM that zeroes the RAM after reset.
module slc3_memory #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic        mem_mem_ena,
    input  logic        mem_wr_ena,
    output logic [15:0] mem_rdata,
    input  logic [15:0] sw_i,
    output logic [15:0] hex_o,
    output logic        init_busy_o
);

    localparam int          DEPTH = 1 << ADDR_WIDTH;
    // 17-bit limit so the compare is exact for every legal ADDR_WIDTH.
    localparam logic [16:0] LIMIT = 17'(DEPTH);

    logic [15:0]           ram [DEPTH];
    logic [15:0]           sw_meta;
    logic [15:0]           sw_sync;
    logic                  is_io;
    logic                  is_ram;
    logic                  active;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [15:0]           ram_wdata;

    // Upper bits must be zero for a RAM hit, so holes never alias into the RAM.
    assign is_io  = (mem_addr == 16'hFFFF);
    assign is_ram = ({1'b0, mem_addr} < LIMIT);

`ifdef SLC3_MEM_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  busy;

    // busy is a registered copy of (state == CLEAR) so init_busy_o is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
            if (clr_cnt == {ADDR_WIDTH{1'b1}}) begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end
    end

    assign init_busy_o = busy;

    // While clearing, the sequencer owns the RAM write port and the bus is ignored.
    always_comb begin
        active    = !busy;
        ram_we    = !reset && (busy || (mem_mem_ena && mem_wr_ena && is_ram));
        ram_waddr = busy ? clr_cnt : mem_addr[ADDR_WIDTH-1:0];
        ram_wdata = busy ? 16'h0000 : mem_wdata;
    end
`else
    assign init_busy_o = 1'b0;

    always_comb begin
        active    = 1'b1;
        ram_we    = !reset && mem_mem_ena && mem_wr_ena && is_ram;
        ram_waddr = mem_addr[ADDR_WIDTH-1:0];
        ram_wdata = mem_wdata;
    end
`endif

    // RAM array carries no reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta   <= 16'h0000;
            sw_sync   <= 16'h0000;
            hex_o     <= 16'h0000;
            mem_rdata <= 16'h0000;
        end else begin
            sw_meta <= sw_i;
            sw_sync <= sw_meta;
            if (active && mem_mem_ena) begin
                if (mem_wr_ena) begin
                    if (is_io) begin
                        hex_o <= mem_wdata;
                    end
                end else if (is_io) begin
                    mem_rdata <= sw_sync;
                end else if (is_ram) begin
                    mem_rdata <= ram[mem_addr[ADDR_WIDTH-1:0]];
                end else begin
                    mem_rdata <= 16'h0000;
                end
            end
        end
    end

endmodule

// File: tb/tb_slc3_memory.sv
// Purpose: randomized self-checking bench for slc3_memory with a behavioural memory model.
// Latency: expectations are queued per driven cycle and checked one half-cycle after the edge.
// Backpressure: none; the DUT accepts a request every cycle, so one expectation per edge.
module tb_slc3_memory;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
`ifdef SLC3_MEM_CLEAR_EN
    localparam bit CLEAR_ON = 1'b1;
`else
    localparam bit CLEAR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mem_addr = 16'h0000;
    logic [15:0] mem_wdata = 16'h0000;
    logic        mem_mem_ena = 1'b0;
    logic        mem_wr_ena = 1'b0;
    logic [15:0] mem_rdata;
    logic [15:0] sw_i = 16'h0000;
    logic [15:0] hex_o;
    logic        init_busy_o;

    slc3_memory #(.ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_mem_ena (mem_mem_ena),
        .mem_wr_ena  (mem_wr_ena),
        .mem_rdata   (mem_rdata),
        .sw_i        (sw_i),
        .hex_o       (hex_o),
        .init_busy_o (init_busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] rdata;
        logic [15:0] hex;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   cur_vld = 1'b0;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] mem [DEPTH];
    logic [15:0] m_rdata = 16'h0000;
    logic [15:0] m_hex = 16'h0000;
    int          busy_left = 0;
    logic [15:0] sw_hist[$];   // switch value seen by the DUT at each driven edge (0 on reset edges)
    logic [15:0] sw_val = 16'h0000;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            if (bad <= 25) begin
                $display("FAIL %s at %0t: got=%h want=%h", name, $time, got, want);
            end
        end
    endtask

    // Monitor: entries pushed before this edge describe the state right after it.
    always @(posedge clk) begin
        cur_vld = 1'b0;
        if (exp_q.size() > 0) begin
            cur     = exp_q.pop_front();
            cur_vld = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cur_vld) begin
            check("rdata", mem_rdata, cur.rdata);
            check("hex",   hex_o,     cur.hex);
            check("busy",  {15'h0, init_busy_o}, {15'h0, cur.busy});
        end
    end

    // Drive one cycle and push the model's prediction for the state after the coming edge.
    task automatic drive(input bit rst, input bit ena, input bit wr,
                         input logic [15:0] addr, input logic [15:0] data);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = rst;
        mem_mem_ena = ena;
        mem_wr_ena  = wr;
        mem_addr    = addr;
        mem_wdata   = data;
        sw_i        = sw_val;
        if (rst) begin
            sw_hist.push_back(16'h0000);
            m_rdata   = 16'h0000;
            m_hex     = 16'h0000;
            busy_left = CLEAR_ON ? DEPTH : 0;
        end else begin
            sw_hist.push_back(sw_val);
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;
                end
            end else if (ena) begin
                if (wr) begin
                    if (addr == 16'hFFFF)          m_hex = data;
                    else if (int'(addr) < DEPTH)   mem[addr[AW-1:0]] = data;
                end else begin
                    // Switch value returned is the one applied two edges earlier.
                    if (addr == 16'hFFFF)          m_rdata = sw_hist[sw_hist.size()-3];
                    else if (int'(addr) < DEPTH)   m_rdata = mem[addr[AW-1:0]];
                    else                           m_rdata = 16'h0000;
                end
            end
        end
        e.rdata = m_rdata;
        e.hex   = m_hex;
        e.busy  = (busy_left > 0);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    function automatic logic [15:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1, 2, 3, 4: return 16'($urandom_range(0, DEPTH - 1));
            5:             return 16'(DEPTH - 1);
            6:             return 16'(DEPTH);
            7:             return 16'hFFFF;
            8:             return 16'($urandom_range(DEPTH, 16'hFFFE));
            default:       return 16'h0000;
        endcase
    endfunction

    // Random traffic while boot-clear runs; all of it must be dropped.
    task automatic run_clear();
        while (busy_left > 0) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  (busy_left % 3 == 0) ? 16'h0003 : rand_addr(), 16'($urandom));
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;

        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        run_clear();

        // Define every RAM word so any later read has a known answer.
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 1'b1, 16'(i), 16'($urandom));

        // Boot-clear with a pre-written word, then reset mid-clear.
        drive(1'b0, 1'b1, 1'b1, 16'h0003, 16'hFFFF);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        if (CLEAR_ON) begin
            idle(7);
            drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        end
        run_clear();
        drive(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 1'b1, 16'(i), 16'($urandom));

        // Write then read, result held over idle cycles.
        drive(1'b0, 1'b1, 1'b1, 16'h0005, 16'h1234);
        drive(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000);
        idle(3);

        // I/O write and switch read.
        drive(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hBEEF);
        sw_val = 16'h00A5;
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000);
        idle(1);

        // Hole and boundary.
        drive(1'b0, 1'b1, 1'b1, 16'h0400, 16'h7777);
        drive(1'b0, 1'b1, 1'b0, 16'h0400, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 16'h03FF, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);

        // Back-to-back requests.
        drive(1'b0, 1'b1, 1'b1, 16'h0001, 16'h1111);
        drive(1'b0, 1'b1, 1'b1, 16'h0002, 16'h2222);
        drive(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000);

        // Random traffic with occasional switch changes and resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) sw_val = 16'($urandom);
            if ($urandom_range(0, 999) == 0) begin
                drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
                run_clear();
            end else begin
                drive(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      rand_addr(), 16'($urandom));
            end
        end

        idle(2);
        @(posedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d left want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
